// File: rtl/dm_sram_responder.sv
// Data-memory responder: accepts one MEM-stage load/store at a time and sequences an
// asynchronous 32-bit SRAM, stalling the pipeline until the access retires.
module dm_sram_responder #(
  parameter int ADDR_W   = 20,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       dm_addr_i,
  input  logic              dm_re_i,
  input  logic              dm_we_i,
  input  logic [3:0]        dm_wbe_n_i,
  input  logic [31:0]       dm_wdata_i,
  output logic [31:0]       dm_rdata_o,
  output logic              dm_stall_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [31:0]       sram_data_o,
  output logic              sram_data_oe_o,
  input  logic [31:0]       sram_data_i
);

  localparam int MAX_WAIT = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_PULSE - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [3:0]        mask_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;
  logic              ce_n_r;
  logic              oe_n_r;
  logic              we_n_r;
  logic              data_oe_r;
  logic [3:0]        be_n_r;
  logic              ce_n_nxt_s;
  logic              oe_n_nxt_s;
  logic              we_n_nxt_s;
  logic              data_oe_nxt_s;
  logic [3:0]        be_n_nxt_s;
  logic [3:0]        mask_s;
  logic              req_s;
  logic              accept_s;
  logic              capture_s;
  logic              unused_s;

  assign req_s    = (dm_re_i | dm_we_i) & (dm_wbe_n_i != 4'b1111);
  assign accept_s = (state_r == ST_IDLE) & req_s;
  // The write mask is not latched yet on the accepting edge, so take it from the port.
  assign mask_s   = (state_r == ST_IDLE) ? dm_wbe_n_i : mask_r;
  assign unused_s = ^{dm_addr_i[31:ADDR_W+2], dm_addr_i[1:0]};

  // Next-state and wait-counter sequencing.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (req_s) begin
          if (dm_we_i) begin
            state_nxt_s = ST_WR_SETUP;
          end else begin
            state_nxt_s = ST_RD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (cnt_r == RD_LAST) begin
          state_nxt_s = ST_DONE;
          cnt_nxt_s   = CNT_ZERO;
          capture_s   = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_WR_SETUP: begin
        state_nxt_s = ST_WR_PULSE;
        cnt_nxt_s   = CNT_ZERO;
      end
      ST_WR_PULSE: begin
        if (cnt_r == WR_LAST) begin
          state_nxt_s = ST_WR_HOLD;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_WR_HOLD: begin
        state_nxt_s = ST_DONE;
        cnt_nxt_s   = CNT_ZERO;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Strobe decode from the state being entered, so every pad strobe leaves a flop.
  always_comb begin
    ce_n_nxt_s    = 1'b1;
    oe_n_nxt_s    = 1'b1;
    we_n_nxt_s    = 1'b1;
    data_oe_nxt_s = 1'b0;
    be_n_nxt_s    = 4'b1111;
    case (state_nxt_s)
      ST_RD: begin
        ce_n_nxt_s = 1'b0;
        oe_n_nxt_s = 1'b0;
        be_n_nxt_s = 4'b0000;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        ce_n_nxt_s    = 1'b0;
        data_oe_nxt_s = 1'b1;
        be_n_nxt_s    = mask_s;
      end
      ST_WR_PULSE: begin
        ce_n_nxt_s    = 1'b0;
        we_n_nxt_s    = 1'b0;
        data_oe_nxt_s = 1'b1;
        be_n_nxt_s    = mask_s;
      end
      default: begin
        ce_n_nxt_s    = 1'b1;
        oe_n_nxt_s    = 1'b1;
        we_n_nxt_s    = 1'b1;
        data_oe_nxt_s = 1'b0;
        be_n_nxt_s    = 4'b1111;
      end
    endcase
  end

  // State, counter and pad strobe registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      ce_n_r    <= 1'b1;
      oe_n_r    <= 1'b1;
      we_n_r    <= 1'b1;
      data_oe_r <= 1'b0;
      be_n_r    <= 4'b1111;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      ce_n_r    <= ce_n_nxt_s;
      oe_n_r    <= oe_n_nxt_s;
      we_n_r    <= we_n_nxt_s;
      data_oe_r <= data_oe_nxt_s;
      be_n_r    <= be_n_nxt_s;
    end
  end

  // Request capture on acceptance; address and data then hold until the next access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_r  <= {ADDR_W{1'b0}};
      mask_r  <= 4'b1111;
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      addr_r  <= dm_addr_i[ADDR_W+1:2];
      mask_r  <= dm_wbe_n_i;
      wdata_r <= dm_wdata_i;
    end else begin
      addr_r  <= addr_r;
      mask_r  <= mask_r;
      wdata_r <= wdata_r;
    end
  end

  // Read word capture on the final RD edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_r <= 32'h0000_0000;
    end else if (capture_s) begin
      rdata_r <= sram_data_i;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign dm_stall_o     = accept_s | (state_r == ST_RD) | (state_r == ST_WR_SETUP) |
                          (state_r == ST_WR_PULSE) | (state_r == ST_WR_HOLD);
  assign dm_rdata_o     = rdata_r;
  assign sram_addr_o    = addr_r;
  assign sram_be_n_o    = be_n_r;
  assign sram_ce_n_o    = ce_n_r;
  assign sram_oe_n_o    = oe_n_r;
  assign sram_we_n_o    = we_n_r;
  assign sram_data_o    = wdata_r;
  assign sram_data_oe_o = data_oe_r;

endmodule

// File: tb/tb_dm_sram_responder.sv
// Bench for dm_sram_responder: a default instance checked every cycle against a
// transaction-level timeline model, plus a RD_WAIT=3/WR_PULSE=1 instance for latency.
`timescale 1ns/1ps
module tb_dm_sram_responder;
  localparam int AW   = 20;
  localparam int A_RW = 1;
  localparam int A_WP = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [31:0] a_addr, a_wdata, a_rdata, a_sdo, a_sdi;
  logic        a_re, a_we, a_stall, a_ce, a_oe, a_wen, a_doe;
  logic [3:0]  a_wbe, a_be;
  logic [AW-1:0] a_saddr;
  logic [31:0] b_addr, b_wdata, b_rdata, b_sdo, b_sdi;
  logic        b_re, b_we, b_stall, b_ce, b_oe, b_wen, b_doe;
  logic [3:0]  b_wbe, b_be;
  logic [AW-1:0] b_saddr;

  dm_sram_responder #(.ADDR_W(AW), .RD_WAIT(A_RW), .WR_PULSE(A_WP)) u_a (
    .clk(clk), .resetn(resetn), .dm_addr_i(a_addr), .dm_re_i(a_re), .dm_we_i(a_we),
    .dm_wbe_n_i(a_wbe), .dm_wdata_i(a_wdata), .dm_rdata_o(a_rdata), .dm_stall_o(a_stall),
    .sram_addr_o(a_saddr), .sram_be_n_o(a_be), .sram_ce_n_o(a_ce), .sram_oe_n_o(a_oe),
    .sram_we_n_o(a_wen), .sram_data_o(a_sdo), .sram_data_oe_o(a_doe), .sram_data_i(a_sdi));

  dm_sram_responder #(.ADDR_W(AW), .RD_WAIT(3), .WR_PULSE(1)) u_b (
    .clk(clk), .resetn(resetn), .dm_addr_i(b_addr), .dm_re_i(b_re), .dm_we_i(b_we),
    .dm_wbe_n_i(b_wbe), .dm_wdata_i(b_wdata), .dm_rdata_o(b_rdata), .dm_stall_o(b_stall),
    .sram_addr_o(b_saddr), .sram_be_n_o(b_be), .sram_ce_n_o(b_ce), .sram_oe_n_o(b_oe),
    .sram_we_n_o(b_wen), .sram_data_o(b_sdo), .sram_data_oe_o(b_doe), .sram_data_i(b_sdi));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot = n_tot + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 4) return 32'hDEAD_BEEF;
    return {8'hA5, b, 8'h5A, b};
  endfunction

  // SRAM model for instance A: async read, byte-masked write while we_n is low.
  logic [31:0] mem [0:255];
  assign a_sdi = (!a_ce && !a_oe) ? mem[a_saddr[7:0]] : 32'h0;
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (!a_ce && !a_wen) begin
      for (int b = 0; b < 4; b++)
        if (!a_be[b]) mem[a_saddr[7:0]][8*b +: 8] <= a_sdo[8*b +: 8];
    end
  end
  assign b_sdi = (!b_ce && !b_oe) ? 32'h1234_5678 : 32'h0;

  // Timeline model for A: each accepted access occupies fixed phases after acceptance.
  logic [31:0] ref_mem [0:255];
  bit          busy, m_wr, acc;
  int          ph, len;
  logic [AW-1:0] m_addr;
  logic [3:0]  m_mask;
  logic [31:0] m_wdata, m_rexp, last_rd;
  logic        e_stall, e_ce, e_oe, e_we, e_doe;
  logic [3:0]  e_be;

  always @(negedge clk) begin
    if (!resetn) begin
      busy = 1'b0; ph = 0; m_addr = '0; m_wdata = '0; last_rd = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    end else begin
      e_stall = 1'b0; e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_be = 4'hF; e_doe = 1'b0;
      acc = 1'b0;
      if (!busy) begin
        acc = (a_re | a_we) && (a_wbe != 4'hF);
        e_stall = acc;
      end else begin
        ph  = ph + 1;
        len = m_wr ? A_WP + 3 : A_RW + 1;
        if (ph < len) begin
          e_stall = 1'b1; e_ce = 1'b0;
          if (m_wr) begin
            e_be = m_mask; e_doe = 1'b1;
            e_we = (ph >= 2 && ph <= A_WP + 1) ? 1'b0 : 1'b1;
          end else begin
            e_oe = 1'b0; e_be = 4'h0;
          end
        end else begin
          if (!m_wr) last_rd = m_rexp;
          busy = 1'b0;
        end
      end
      chk("stall", 32'(a_stall), 32'(e_stall));
      chk("ce_n", 32'(a_ce), 32'(e_ce));
      chk("oe_n", 32'(a_oe), 32'(e_oe));
      chk("we_n", 32'(a_wen), 32'(e_we));
      chk("be_n", 32'(a_be), 32'(e_be));
      chk("data_oe", 32'(a_doe), 32'(e_doe));
      chk("sram_addr", 32'(a_saddr), 32'(m_addr));
      chk("sram_data", a_sdo, m_wdata);
      chk("rdata", a_rdata, last_rd);
      chk("no_oe_with_doe", 32'(!(a_oe == 1'b0 && a_doe == 1'b1)), 32'd1);
      if (acc) begin
        busy = 1'b1; ph = 0; m_wr = a_we; m_addr = a_addr[AW+1:2];
        m_mask = a_wbe; m_wdata = a_wdata;
        if (m_wr) begin
          for (int b = 0; b < 4; b++)
            if (!m_mask[b]) ref_mem[m_addr[7:0]][8*b +: 8] = m_wdata[8*b +: 8];
        end else begin
          m_rexp = ref_mem[m_addr[7:0]];
        end
      end
    end
  end

  task automatic drive(input bit sel, input logic re, input logic we, input logic [31:0] addr,
                       input logic [3:0] wbe, input logic [31:0] wd);
    if (sel) begin b_re = re; b_we = we; b_addr = addr; b_wbe = wbe; b_wdata = wd; end
    else     begin a_re = re; a_we = we; a_addr = addr; a_wbe = wbe; a_wdata = wd; end
  endtask

  // Presents one request (caller is just after a rising edge) and measures it up to DONE.
  task automatic do_acc(input bit sel, input logic re, input logic we, input logic [31:0] addr,
                        input logic [3:0] wbe, input logic [31:0] wd, input bit hold,
                        output int n_stall, output int n_wel, output int n_be,
                        output int first_wel, output logic [31:0] rd, output logic oe_d);
    bit done;
    logic st, wl;
    logic [3:0] be;
    drive(sel, re, we, addr, wbe, wd);
    n_stall = 0; n_wel = 0; n_be = 0; first_wel = -1; rd = '0; oe_d = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      st = sel ? b_stall : a_stall;
      wl = sel ? b_wen : a_wen;
      be = sel ? b_be : a_be;
      if (!wl) begin n_wel++; if (first_wel < 0) first_wel = k; end
      if (be != 4'hF) n_be++;
      if (st) n_stall++;
      else begin done = 1'b1; rd = sel ? b_rdata : a_rdata; oe_d = sel ? b_oe : a_oe; end
    end
    if (!done) chk("access_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
    if (!hold) drive(sel, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int ns, nw, nb, fw;
  logic [31:0] rd;
  logic oe_d;
  bit seen;

  initial begin
    resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_stall", 32'(a_stall), 32'd0);
    chk("rst_addr", 32'(a_saddr), 32'h0);
    chk("rst_be_n", 32'(a_be), 32'hF);
    chk("rst_strobes", {29'd0, a_ce, a_oe, a_wen}, 32'h7);
    chk("rst_data", a_sdo, 32'h0);
    chk("rst_doe", 32'(a_doe), 32'd0);
    chk("rst_b_strobes", {29'd0, b_ce, b_oe, b_wen}, 32'h7);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Word load
    do_acc(1'b0, 1'b1, 1'b0, 32'h0000_0010, 4'b0000, 32'h0, 1'b0, ns, nw, nb, fw, rd, oe_d);
    chk("load_stall_cycles", 32'(ns), 32'd2);
    chk("load_rdata", rd, 32'hDEAD_BEEF);
    chk("load_oe_in_done", 32'(oe_d), 32'd1);
    chk("load_addr", 32'(a_saddr), 32'h4);

    // Byte store to byte 3 of word 8
    do_acc(1'b0, 1'b0, 1'b1, 32'h0000_0023, 4'b0111, 32'hAB00_0000, 1'b0, ns, nw, nb, fw, rd, oe_d);
    chk("bstore_stall_cycles", 32'(ns), 32'd5);
    chk("bstore_be_cycles", 32'(nb), 32'd4);
    chk("bstore_we_cycles", 32'(nw), 32'd2);
    chk("bstore_we_first", 32'(fw), 32'd2);
    chk("bstore_mem", mem[8], 32'hAB08_5A08);
    chk("bstore_neighbor", mem[9], 32'hA509_5A09);

    // Request with all-ones mask is not a request
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0010, 4'b1111, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_mask_stall", 32'(a_stall), 32'd0);
      chk("idle_mask_ce", 32'(a_ce), 32'd1);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0);

    // Back-to-back store then load, inputs held while stalled
    do_acc(1'b0, 1'b0, 1'b1, 32'h0000_0040, 4'b0000, 32'h1122_3344, 1'b1, ns, nw, nb, fw, rd, oe_d);
    chk("b2b_store_stall", 32'(ns), 32'd5);
    do_acc(1'b0, 1'b1, 1'b0, 32'h0000_0040, 4'b0000, 32'h0, 1'b0, ns, nw, nb, fw, rd, oe_d);
    chk("b2b_load_stall", 32'(ns), 32'd2);
    chk("b2b_load_rdata", rd, 32'h1122_3344);

    // re and we together resolve to a write
    do_acc(1'b0, 1'b1, 1'b1, 32'h0000_0044, 4'b0000, 32'hCAFE_F00D, 1'b0, ns, nw, nb, fw, rd, oe_d);
    chk("rw_both_stall", 32'(ns), 32'd5);
    chk("rw_both_rdata_kept", rd, 32'h1122_3344);
    do_acc(1'b0, 1'b1, 1'b0, 32'h0000_0044, 4'b0000, 32'h0, 1'b0, ns, nw, nb, fw, rd, oe_d);
    chk("rw_both_readback", rd, 32'hCAFE_F00D);

    // Parameter sweep instance
    do_acc(1'b1, 1'b1, 1'b0, 32'h0000_0100, 4'b0000, 32'h0, 1'b0, ns, nw, nb, fw, rd, oe_d);
    chk("sweep_load_stall", 32'(ns), 32'd4);
    chk("sweep_load_rdata", rd, 32'h1234_5678);
    chk("sweep_load_addr", 32'(b_saddr), 32'h40);
    do_acc(1'b1, 1'b0, 1'b1, 32'h0000_0104, 4'b1100, 32'h0000_BEEF, 1'b0, ns, nw, nb, fw, rd, oe_d);
    chk("sweep_store_stall", 32'(ns), 32'd4);
    chk("sweep_store_we_cycles", 32'(nw), 32'd1);
    chk("sweep_store_be_cycles", 32'(nb), 32'd3);

    // Asynchronous reset in the middle of a write pulse
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0080, 4'b0000, 32'h5555_AAAA);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (!a_wen) seen = 1'b1;
    end
    chk("midwr_reached_pulse", 32'(seen), 32'd1);
    #2;
    resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
    #1;
    chk("midwr_strobes", {29'd0, a_ce, a_oe, a_wen}, 32'h7);
    chk("midwr_doe", 32'(a_doe), 32'd0);
    chk("midwr_be_n", 32'(a_be), 32'hF);
    chk("midwr_stall", 32'(a_stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midwr_no_resume_ce", 32'(a_ce), 32'd1);
      chk("midwr_no_resume_we", 32'(a_wen), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
